// File: rtl/flt2int_unit.sv
// Iterative 16-bit float (1/5/10, bias 15) to 16-bit signed integer converter.
// Define FLT2INT_ROUND_EN for round-to-nearest-even; otherwise results truncate toward zero.
module flt2int_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] flt_in,
  output logic [15:0] int_out,
  output logic        ovf,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, ROUND, DONE} state_t;

  state_t      state, state_next;
  logic [15:0] flt_reg;
  logic [15:0] mag;
  logic [15:0] rounded;
  logic [3:0]  cnt;
  logic        left;
`ifdef FLT2INT_ROUND_EN
  logic        guard;
  logic        sticky;
`endif

  logic        sgn;
  logic [4:0]  expo;
  logic [9:0]  mant;
  logic        is_small;
  logic        is_maxneg;
  logic        is_sat;
  logic [3:0]  k;

  assign sgn  = flt_reg[15];
  assign expo = flt_reg[14:10];
  assign mant = flt_reg[9:0];

  // Operands outside the shifter's range bypass it and finish straight from LOAD.
  assign is_small  = (expo < 5'd14);
  assign is_maxneg = (expo == 5'd30) && (mant == 10'd0) && sgn;
  assign is_sat    = (expo >= 5'd30);
  assign k = (expo > 5'd25) ? 4'(expo - 5'd25) : 4'(5'd25 - expo);

`ifdef FLT2INT_ROUND_EN
  assign rounded = mag + {15'd0, guard & (sticky | mag[0])};
`else
  assign rounded = mag;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = LOAD;
      LOAD: begin
        if (is_small || is_sat) state_next = DONE;
        else if (k != 4'd0)     state_next = SHIFT;
        else                    state_next = ROUND;
      end
      SHIFT:   if (cnt == 4'd1) state_next = ROUND;
      ROUND:   state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flt_reg <= 16'd0;
      mag     <= 16'd0;
      cnt     <= 4'd0;
      left    <= 1'b0;
      int_out <= 16'd0;
      ovf     <= 1'b0;
      done    <= 1'b0;
`ifdef FLT2INT_ROUND_EN
      guard   <= 1'b0;
      sticky  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            flt_reg <= flt_in;
            done    <= 1'b0;
            ovf     <= 1'b0;
          end
        end
        LOAD: begin
          if (is_small) begin
            int_out <= 16'h0000;
            done    <= 1'b1;
          end else if (is_maxneg) begin
            int_out <= 16'h8000;
            done    <= 1'b1;
          end else if (is_sat) begin
            int_out <= sgn ? 16'h8000 : 16'h7FFF;
            ovf     <= 1'b1;
            done    <= 1'b1;
          end else begin
            mag    <= {5'd0, 1'b1, mant};
            cnt    <= k;
            left   <= (expo > 5'd25);
`ifdef FLT2INT_ROUND_EN
            guard  <= 1'b0;
            sticky <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          cnt <= cnt - 4'd1;
          if (left) begin
            mag <= {mag[14:0], 1'b0};
          end else begin
            mag    <= {1'b0, mag[15:1]};
`ifdef FLT2INT_ROUND_EN
            guard  <= mag[0];
            sticky <= sticky | guard;
`endif
          end
        end
        ROUND: begin
          int_out <= sgn ? (~rounded + 16'd1) : rounded;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flt2int_unit.sv
// Directed and round-trip bench for flt2int_unit; expectations follow FLT2INT_ROUND_EN.
module tb_flt2int_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] flt_in;
  logic [15:0] int_out;
  logic        ovf;
  logic        done;

  int testsRun = 0;
  int testsFailed = 0;

  flt2int_unit dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .flt_in  (flt_in),
    .int_out (int_out),
    .ovf     (ovf),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] flt;
    logic [15:0] res;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vecs [17];

  // One comparison: counts it and reports a failure line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Pulses start for one edge, then waits (bounded) for done; lat counts edges from accept.
  task automatic applyStimulus(input logic [15:0] f, output logic [15:0] res, output logic o, output int lat);
    @(negedge clk);
    flt_in = f;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = c;
        break;
      end
    end
    res = int_out;
    o   = ovf;
  endtask

  // Reference int-to-float encoder with round-to-nearest-even; also returns the value the float represents.
  task automatic int2fltModel(input logic signed [15:0] x, output logic [15:0] f,
                              output logic [15:0] expRes, output logic expOvf);
    int m, p, sh, kept, rem, half, val;
    logic s;
    s = x[15];
    m = s ? -int'(x) : int'(x);
    expOvf = 1'b0;
    if (m == 0) begin
      f = 16'h0000;
      val = 0;
    end else begin
      p = 0;
      for (int i = 0; i < 17; i++) if ((m >> i) & 1) p = i;
      if (p <= 10) begin
        kept = m << (10 - p);
        val  = m;
      end else begin
        sh   = p - 10;
        kept = m >> sh;
        rem  = m & ((1 << sh) - 1);
        half = 1 << (sh - 1);
        if (rem > half || (rem == half && (kept & 1) == 1)) kept++;
        if (kept == 2048) begin
          kept = 1024;
          p++;
          sh++;
        end
        val = kept << sh;
      end
      f = {s, 5'(p + 15), 10'(kept & 1023)};
    end
    if (!s && val > 32767) begin
      expRes = 16'h7FFF;
      expOvf = 1'b1;
    end else begin
      expRes = s ? 16'(-val) : 16'(val);
    end
  endtask

  initial begin
    logic [15:0] res, f, er;
    logic        o, eo;
    int          lat, hiRun, loRun, seen;

    vecs[0]  = '{"one",       16'h3C00, 16'h0001, 1'b0, 12};
    vecs[1]  = '{"two",       16'h4000, 16'h0002, 1'b0, 11};
    vecs[2]  = '{"neg_two",   16'hC000, 16'hFFFE, 1'b0, 11};
    vecs[3]  = '{"e29_max",   16'h77FF, 16'h7FF0, 1'b0, 6};
    vecs[4]  = '{"e25_1024",  16'h6400, 16'h0400, 1'b0, 2};
    vecs[5]  = '{"half",      16'h3800, 16'h0000, 1'b0, 13};
    vecs[6]  = '{"two_half",  16'h4100, 16'h0002, 1'b0, 11};
`ifdef FLT2INT_ROUND_EN
    vecs[7]  = '{"one_half",  16'h3E00, 16'h0002, 1'b0, 12};
    vecs[8]  = '{"three_q",   16'h3A00, 16'h0001, 1'b0, 13};
    vecs[9]  = '{"neg_1_5",   16'hBE00, 16'hFFFE, 1'b0, 12};
`else
    vecs[7]  = '{"one_half",  16'h3E00, 16'h0001, 1'b0, 12};
    vecs[8]  = '{"three_q",   16'h3A00, 16'h0000, 1'b0, 13};
    vecs[9]  = '{"neg_1_5",   16'hBE00, 16'hFFFF, 1'b0, 12};
`endif
    vecs[10] = '{"max_neg",   16'hF800, 16'h8000, 1'b0, 1};
    vecs[11] = '{"sat_pos",   16'h7800, 16'h7FFF, 1'b1, 1};
    vecs[12] = '{"sat_nan",   16'hFC01, 16'h8000, 1'b1, 1};
    vecs[13] = '{"denorm",    16'h0155, 16'h0000, 1'b0, 1};
    vecs[14] = '{"tiny",      16'h3000, 16'h0000, 1'b0, 1};
    vecs[15] = '{"e13_max",   16'h37FF, 16'h0000, 1'b0, 1};
    vecs[16] = '{"sat_neg31", 16'hFC00, 16'h8000, 1'b1, 1};

    reset  = 1'b1;
    start  = 1'b0;
    flt_in = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_int_out", 32'(int_out), 32'h0);
    checkOutput("reset_ovf", 32'(ovf), 32'h0);
    checkOutput("reset_done", 32'(done), 32'h0);
    reset = 1'b0;

    // Reset one edge after accept aborts the conversion.
    @(negedge clk);
    flt_in = 16'h3C00;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("abort_done", 32'(done), 32'h0);
    checkOutput("abort_int_out", 32'(int_out), 32'h0);
    seen = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    checkOutput("abort_no_done", 32'(seen), 32'h0);
    applyStimulus(16'h4000, res, o, lat);
    checkOutput("after_abort_res", 32'(res), 32'h0002);
    checkOutput("after_abort_lat", 32'(lat), 32'd11);

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].flt, res, o, lat);
      checkOutput({vecs[i].name, "_res"}, 32'(res), 32'(vecs[i].res));
      checkOutput({vecs[i].name, "_ovf"}, 32'(o), 32'(vecs[i].ovf));
      checkOutput({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
    end

    // Held start: done is high for one cycle, then low for the whole 11-edge busy span.
    @(negedge clk);
    flt_in = 16'h4000;
    start  = 1'b1;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1;
    end
    checkOutput("held_first_done", 32'(seen), 32'h1);
    for (int j = 0; j < 2; j++) begin
      hiRun = 0;
      while (done && hiRun < 20) begin
        hiRun++;
        @(posedge clk);
        #1;
      end
      loRun = 0;
      while (!done && loRun < 20) begin
        loRun++;
        @(posedge clk);
        #1;
      end
      checkOutput("held_high_run", 32'(hiRun), 32'd1);
      checkOutput("held_busy_run", 32'(loRun), 32'd11);
      checkOutput("held_res", 32'(int_out), 32'h0002);
    end
    start = 1'b0;

    // Start pulsed mid-SHIFT with a different operand is ignored.
    @(negedge clk);
    flt_in = 16'h3C00;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    flt_in = 16'h4000;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = -1;
    for (int c = 6; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = c;
        break;
      end
    end
    checkOutput("ignored_start_res", 32'(int_out), 32'h0001);
    checkOutput("ignored_start_lat", 32'(lat), 32'd12);

    for (int n = 0; n < 200; n++) begin
      logic signed [15:0] x;
      x = 16'($urandom_range(0, 65535));
      int2fltModel(x, f, er, eo);
      applyStimulus(f, res, o, lat);
      checkOutput("roundtrip_res", 32'(res), 32'(er));
      checkOutput("roundtrip_ovf", 32'(o), 32'(eo));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
